// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: host request/response channel plus APB master bus bundle
//   master modport: bridge side, drives req_ready, rsp_*, err_cnt and the APB controls
//   slave modport : host and APB slave side, drives requests, rsp_ready, PRDATA, PREADY, PSLVERR
interface apb_master_bridge_if #(
   parameter int APB_AW = 32,
   parameter int APB_DW = 32
);
   logic              req_valid, req_ready, req_write;
   logic [APB_AW-1:0] req_addr;
   logic [APB_DW-1:0] req_wdata;
   logic              rsp_valid, rsp_ready, rsp_err;
   logic [APB_DW-1:0] rsp_rdata;
   logic [7:0]        err_cnt;
   logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [APB_AW-1:0] PADDR;
   logic [APB_DW-1:0] PWDATA, PRDATA;
   modport master (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
   modport slave (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_cnt, PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: host valid/ready single-word requests to AMBA 3 APB transfers with error capture
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : apb_master_bridge_if.master (host req/rsp channel, err_cnt, APB master signals)
//   APB_BRIDGE_TIMEOUT_EN: when defined, ACCESS aborts with an error after TIMEOUT_CYCLES wait cycles
module apb_master_bridge #(
   parameter int APB_AW         = 32,
   parameter int APB_DW         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   apb_master_bridge_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t            r_state;
   logic              r_psel, r_penable, r_pwrite, r_err;
   logic [APB_AW-1:0] r_paddr;
   logic [APB_DW-1:0] r_pwdata, r_rdata;
   logic [7:0]        r_err_cnt;
   logic              w_done, w_err;
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be >= 1");
   end
`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] r_cnt;
   logic          w_tmo;
   assign w_tmo  = r_cnt == TMO_LAST;
   // PREADY in the last counted cycle still completes normally
   assign w_done = bus.PREADY || w_tmo;
   assign w_err  = !bus.PREADY || bus.PSLVERR;
`else
   assign w_done = bus.PREADY;
   assign w_err  = bus.PSLVERR;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else
         case (r_state)
            IDLE:
               if (bus.req_valid) begin
                  r_state  <= SETUP;
                  r_psel   <= 1'b1;
                  r_pwrite <= bus.req_write;
                  r_paddr  <= bus.req_addr;
                  r_pwdata <= bus.req_wdata;
               end
            SETUP: begin
               r_state   <= ACCESS;
               r_penable <= 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
               r_cnt     <= '0;
`endif
            end
            ACCESS: begin
               if (w_done) begin
                  r_state   <= RESP;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_err     <= w_err;
                  r_rdata   <= (!r_pwrite && !w_err) ? bus.PRDATA : '0;
                  if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
               end
`ifdef APB_BRIDGE_TIMEOUT_EN
               else r_cnt <= r_cnt + 1'b1;
`endif
            end
            RESP:
               if (bus.rsp_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
   // handshake flags decode straight from state so they drop the instant reset asserts
   assign bus.req_ready = rst_n && r_state == IDLE;
   assign bus.rsp_valid = r_state == RESP;
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;
   assign bus.err_cnt   = r_err_cnt;
   assign bus.PSEL      = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PADDR     = r_paddr;
   assign bus.PWDATA    = r_pwdata;
endmodule
